// File: rtl/imm_packer_pkg.sv
// Shared core definitions for immediate handling: the immediate-format
// encoding used by the packer and the immediate decoder, bus widths, and the
// field-placement function that inserts an immediate into an instruction word.
package imm_packer_pkg;

  localparam int unsigned IMM_SRC_W = 3;
  localparam int unsigned IMM_W     = 64;
  localparam int unsigned INSTR_W   = 32;

  // Immediate formats; encodings 101..111 are reserved.
  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  // Overlay the (truncated) immediate fields of the selected format onto the
  // base instruction. Bits not owned by the format keep the base value, and a
  // reserved format passes the base through untouched.
  function automatic logic [INSTR_W-1:0] imm_encode(
    input logic [IMM_SRC_W-1:0] src,
    input logic [IMM_W-1:0]     imm,
    input logic [INSTR_W-1:0]   base
  );
    logic [INSTR_W-1:0] r;
    r = base;
    case (src)
      IMM_I: r[31:20] = imm[11:0];
      IMM_S: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      IMM_B: begin
        r[31]    = imm[12];
        r[7]     = imm[11];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
      end
      IMM_J: begin
        r[31]    = imm[20];
        r[19:12] = imm[19:12];
        r[20]    = imm[11];
        r[30:21] = imm[10:1];
      end
      IMM_U:   r[31:12] = imm[31:12];
      default: r = base;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_packer_if.sv
// Request/response bus of the immediate packer.
//   master: drives the request (in_*) and out_ready, observes the response
//   slave : the packer itself
interface imm_packer_if
  import imm_packer_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IMM_SRC_W-1:0] in_imm_source;
  logic [IMM_W-1:0]     in_immediate;
  logic [INSTR_W-1:0]   in_base_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_W-1:0]   out_instr;
  logic                 out_range_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_imm_source, in_immediate, in_base_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_range_err, err_count
  );

  modport slave (
    input  in_valid, in_imm_source, in_immediate, in_base_instr, out_ready,
    output in_ready, out_valid, out_instr, out_range_err, err_count
  );
endinterface

// File: rtl/imm_packer_range_check.sv
// imm_range_check: combinational check that an immediate is representable in
// the selected format.
//   imm_source : format select (reserved encodings always flag an error)
//   immediate  : 64-bit signed immediate
//   err        : 1 when the value does not fit
module imm_range_check
  import imm_packer_pkg::*;
(
  input  logic [IMM_SRC_W-1:0] imm_source,
  input  logic [IMM_W-1:0]     immediate,
  output logic                 err
);

  logic is_bad;   // bits 63..11 not a sign extension
  logic b_bad;    // bits 63..12 not a sign extension
  logic j_bad;    // bits 63..20 not a sign extension
  logic u_bad;    // bits 63..31 not a sign extension

  // A field is a valid sign extension when it is all ones or all zeros.
  assign is_bad = ~((&immediate[63:11]) | ~(|immediate[63:11]));
  assign b_bad  = ~((&immediate[63:12]) | ~(|immediate[63:12]));
  assign j_bad  = ~((&immediate[63:20]) | ~(|immediate[63:20]));
  assign u_bad  = ~((&immediate[63:31]) | ~(|immediate[63:31]));

  // Select the check for the requested format; B/J drop bit 0, U drops 11..0.
  always_comb begin
    err = 1'b1;
    case (imm_source)
      IMM_I, IMM_S: err = is_bad;
      IMM_B:        err = b_bad | immediate[0];
      IMM_J:        err = j_bad | immediate[0];
      IMM_U:        err = u_bad | (|immediate[11:0]);
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// imm_packer: two-stage pipeline that inserts a signed immediate into an
// instruction word for the I/S/B/J/U formats and flags out-of-range values.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imm_packer_if slave (request in, encoded instruction out,
//                saturating count of delivered range errors)
// S1 holds the request plus its range-check result, S2 holds the encoded word.
module imm_packer
  import imm_packer_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
)(
  input  logic           clk,
  input  logic           rst_n,
  imm_packer_if.slave    bus
);

  logic                 run_q;
  logic                 s1_valid_q, s1_valid_d;
  logic [IMM_SRC_W-1:0] s1_src_q,   s1_src_d;
  logic [IMM_W-1:0]     s1_imm_q,   s1_imm_d;
  logic [INSTR_W-1:0]   s1_base_q,  s1_base_d;
  logic                 s1_err_q,   s1_err_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [INSTR_W-1:0]   s2_instr_q, s2_instr_d;
  logic                 s2_err_q,   s2_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

  logic range_err_s;
  logic s2_adv_s;
  logic in_ready_s;
  logic in_fire_s;
  logic out_fire_s;

  imm_range_check u_range_check (
    .imm_source (bus.in_imm_source),
    .immediate  (bus.in_immediate),
    .err        (range_err_s)
  );

  // run_q keeps in_ready low until the first edge after reset release.
  assign s2_adv_s   = ~s2_valid_q | bus.out_ready;
  assign in_ready_s = run_q & (~s1_valid_q | s2_adv_s);
  assign in_fire_s  = bus.in_valid & in_ready_s;
  assign out_fire_s = s2_valid_q & bus.out_ready;

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = s2_valid_q;
  assign bus.out_instr     = s2_instr_q;
  assign bus.out_range_err = s2_err_q;
  assign bus.err_count     = err_cnt_q;

  // Next-state for both stages and the error counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_src_d   = s1_src_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    // S2 loads whenever it is empty or being drained; it holds otherwise so a
    // stalled output stays stable.
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = imm_encode(s1_src_q, s1_imm_q, s1_base_q);
        s2_err_d   = s1_err_q;
      end else begin
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_src_d   = bus.in_imm_source;
      s1_imm_d   = bus.in_immediate;
      s1_base_d  = bus.in_base_instr;
      s1_err_d   = range_err_s;
    end else if (s2_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (out_fire_s && s2_err_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Pipeline and counter registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_src_q   <= {IMM_SRC_W{1'b0}};
      s1_imm_q   <= {IMM_W{1'b0}};
      s1_base_q  <= {INSTR_W{1'b0}};
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= {INSTR_W{1'b0}};
      s2_err_q   <= 1'b0;
      err_cnt_q  <= {ERR_CNT_W{1'b0}};
    end else begin
      run_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
